// File: rtl/mmm_kara3_pkg.sv
// Shared types and helpers for the sequential 3-way Karatsuba multiplier.
package mmm_kara3_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StDrain,
        StComb1,
        StComb2,
        StDone
    } kara3_st_e;

    localparam int unsigned NPROD = 6;

    function automatic int unsigned limb_w(input int unsigned idw);
        return (idw + 2) / 3;
    endfunction

endpackage

// File: rtl/kara3_limb_mul.sv
// Pipelined unsigned OW x OW limb multiplier with MUL_LAT register stages, no handshake.
module kara3_limb_mul #(
    parameter int unsigned OW      = 87,
    parameter int unsigned MUL_LAT = 2
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [OW-1:0]   i_a,
    input  logic [OW-1:0]   i_b,
    output logic [2*OW-1:0] o_p
);

    logic [2*OW-1:0] pipe_q [MUL_LAT];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < int'(MUL_LAT); i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= (2*OW)'(i_a) * (2*OW)'(i_b);
            for (int i = 1; i < int'(MUL_LAT); i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign o_p = pipe_q[MUL_LAT-1];

endmodule

// File: rtl/mmm_kara3_seq_mul.sv
// Sequential 3-way Karatsuba multiplier, IDW x IDW -> 2*IDW, one shared limb multiplier.
// Optional squaring input i_sqr is enabled by defining MMM_KARA3_SQR_EN.
module mmm_kara3_seq_mul
    import mmm_kara3_pkg::*;
#(
    parameter int unsigned IDW     = 256,
    parameter int unsigned MUL_LAT = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_vld,
    output logic             o_rdy,
    input  logic [IDW-1:0]   i_a,
    input  logic [IDW-1:0]   i_b,
`ifdef MMM_KARA3_SQR_EN
    input  logic             i_sqr,
`endif
    output logic             o_vld,
    input  logic             i_rdy,
    output logic [2*IDW-1:0] o_res,
    output logic             o_busy
);

    localparam int unsigned W   = limb_w(IDW);
    localparam int unsigned LW3 = 3 * W;
    localparam int unsigned PW  = 2 * W + 2;
    localparam int unsigned RW  = 2 * IDW;

    kara3_st_e        st_q;
    logic [W-1:0]     a_q [3];
    logic [W-1:0]     b_q [3];
    logic [2:0]       iss_cnt_q;
    logic [2:0]       cap_cnt_q;
    logic [W:0]       op_a_q;
    logic [W:0]       op_b_q;
    logic [MUL_LAT:0] pv_q;
    logic [PW-1:0]    p_q [NPROD];
    logic [PW-1:0]    m01_q;
    logic [PW-1:0]    m02_q;
    logic [PW-1:0]    m12_q;
    logic [RW-1:0]    res_q;
    logic             vld_q;

    logic             accept;
    logic [IDW-1:0]   b_src;
    logic [LW3-1:0]   a_pad;
    logic [LW3-1:0]   b_pad;
    logic [W:0]       op_a_d;
    logic [W:0]       op_b_d;
    logic [PW-1:0]    m01_d;
    logic [PW-1:0]    m02_d;
    logic [PW-1:0]    m12_d;
    logic [RW-1:0]    res_d;
    logic [PW-1:0]    mul_p;

    assign o_rdy  = (st_q == StIdle) | ((st_q == StDone) & i_rdy);
    assign o_busy = (st_q != StIdle);
    assign o_vld  = vld_q;
    assign o_res  = res_q;
    assign accept = i_vld & o_rdy;

    always_comb begin
        b_src = i_b;
`ifdef MMM_KARA3_SQR_EN
        if (i_sqr) begin
            b_src = i_a;
        end
`endif
        a_pad = LW3'(i_a);
        b_pad = LW3'(b_src);
    end

    // Issue order: a0b0, a1b1, a2b2, then the three pairwise-sum products.
    always_comb begin
        op_a_d = {1'b0, a_q[0]};
        op_b_d = {1'b0, b_q[0]};
        case (iss_cnt_q)
            3'd1: begin
                op_a_d = {1'b0, a_q[1]};
                op_b_d = {1'b0, b_q[1]};
            end
            3'd2: begin
                op_a_d = {1'b0, a_q[2]};
                op_b_d = {1'b0, b_q[2]};
            end
            3'd3: begin
                op_a_d = {1'b0, a_q[0]} + {1'b0, a_q[1]};
                op_b_d = {1'b0, b_q[0]} + {1'b0, b_q[1]};
            end
            3'd4: begin
                op_a_d = {1'b0, a_q[0]} + {1'b0, a_q[2]};
                op_b_d = {1'b0, b_q[0]} + {1'b0, b_q[2]};
            end
            3'd5: begin
                op_a_d = {1'b0, a_q[1]} + {1'b0, a_q[2]};
                op_b_d = {1'b0, b_q[1]} + {1'b0, b_q[2]};
            end
            default: ;
        endcase
    end

    // Middle terms are cross-product sums, so the modular subtraction never wraps.
    always_comb begin
        m01_d = p_q[3] - p_q[0] - p_q[1];
        m02_d = p_q[4] - p_q[0] - p_q[2] + p_q[1];
        m12_d = p_q[5] - p_q[1] - p_q[2];
        res_d = RW'(p_q[0])
              + (RW'(m01_q) << W)
              + (RW'(m02_q) << (2 * W))
              + (RW'(m12_q) << (3 * W))
              + (RW'(p_q[2]) << (4 * W));
    end

    kara3_limb_mul #(
        .OW      (W + 1),
        .MUL_LAT (MUL_LAT)
    ) u_limb_mul (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_a   (op_a_q),
        .i_b   (op_b_q),
        .o_p   (mul_p)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            st_q      <= StIdle;
            iss_cnt_q <= '0;
            cap_cnt_q <= '0;
            op_a_q    <= '0;
            op_b_q    <= '0;
            pv_q      <= '0;
            m01_q     <= '0;
            m02_q     <= '0;
            m12_q     <= '0;
            res_q     <= '0;
            vld_q     <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                a_q[i] <= '0;
                b_q[i] <= '0;
            end
            for (int i = 0; i < int'(NPROD); i++) begin
                p_q[i] <= '0;
            end
        end else begin
            // pv_q tracks which issued pair reaches the multiplier output this cycle.
            pv_q <= {pv_q[MUL_LAT-1:0], (st_q == StIssue)};
            if (pv_q[MUL_LAT]) begin
                p_q[cap_cnt_q] <= mul_p;
                cap_cnt_q      <= cap_cnt_q + 3'd1;
            end
            if (accept) begin
                for (int i = 0; i < 3; i++) begin
                    a_q[i] <= a_pad[i*W +: W];
                    b_q[i] <= b_pad[i*W +: W];
                end
                iss_cnt_q <= '0;
                cap_cnt_q <= '0;
            end
            case (st_q)
                StIdle: begin
                    if (accept) begin
                        st_q <= StIssue;
                    end
                end
                StIssue: begin
                    op_a_q    <= op_a_d;
                    op_b_q    <= op_b_d;
                    iss_cnt_q <= iss_cnt_q + 3'd1;
                    if (iss_cnt_q == 3'd5) begin
                        st_q <= StDrain;
                    end
                end
                StDrain: begin
                    if (pv_q[MUL_LAT] && (cap_cnt_q == 3'd5)) begin
                        st_q <= StComb1;
                    end
                end
                StComb1: begin
                    m01_q <= m01_d;
                    m02_q <= m02_d;
                    m12_q <= m12_d;
                    st_q  <= StComb2;
                end
                StComb2: begin
                    res_q <= res_d;
                    vld_q <= 1'b1;
                    st_q  <= StDone;
                end
                StDone: begin
                    if (i_rdy) begin
                        vld_q <= 1'b0;
                        st_q  <= accept ? StIssue : StIdle;
                    end
                end
                default: st_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mmm_kara3_seq_mul.sv
// Self-checking bench for mmm_kara3_seq_mul: vector table, latency/handshake/reset sequences,
// random operands against a native wide-multiply model, results checked through a scoreboard.
module tb_mmm_kara3_seq_mul;

    localparam int unsigned IDW     = 256;
    localparam int unsigned MUL_LAT = 2;

    typedef logic [IDW-1:0]   op_t;
    typedef logic [2*IDW-1:0] res_t;
    typedef struct {
        op_t  a;
        op_t  b;
        res_t exp;
    } vec_t;

    logic i_clk = 1'b0;
    logic i_rst;
    logic i_vld;
    logic o_rdy;
    op_t  i_a;
    op_t  i_b;
    logic o_vld;
    logic i_rdy;
    res_t o_res;
    logic o_busy;
`ifdef MMM_KARA3_SQR_EN
    logic i_sqr;
`endif

    int   n_tests = 0;
    int   n_fail  = 0;
    res_t sb [$];

    always #5 i_clk = ~i_clk;

    mmm_kara3_seq_mul #(
        .IDW     (IDW),
        .MUL_LAT (MUL_LAT)
    ) dut (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_vld  (i_vld),
        .o_rdy  (o_rdy),
        .i_a    (i_a),
        .i_b    (i_b),
`ifdef MMM_KARA3_SQR_EN
        .i_sqr  (i_sqr),
`endif
        .o_vld  (o_vld),
        .i_rdy  (i_rdy),
        .o_res  (o_res),
        .o_busy (o_busy)
    );

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check(input string name, input res_t act, input res_t exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic op_t rand_op();
        op_t v;
        for (int w = 0; w < int'(IDW / 32); w++) begin
            v[w*32 +: 32] = $urandom();
        end
        return v;
    endfunction

    // Scoreboard: every completed output handshake pops one expected result.
    always @(negedge i_clk) begin
        if (!i_rst && o_vld && i_rdy) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_result: got %h expected none", o_res);
            end else begin
                check("result", o_res, sb.pop_front());
            end
        end
    end

    task automatic send(input op_t a, input op_t b, input res_t exp, input bit push);
        int n;
        n = 0;
        while (!o_rdy && n < 40) begin
            tick();
            n++;
        end
        if (!o_rdy) begin
            check("rdy_timeout", res_t'(o_rdy), res_t'(1));
        end
        i_vld = 1'b1;
        i_a   = a;
        i_b   = b;
        if (push) begin
            sb.push_back(exp);
        end
        tick();
        i_vld = 1'b0;
        i_a   = rand_op();
        i_b   = rand_op();
    endtask

    task automatic wait_vld(output int n);
        n = 0;
        while (!o_vld && n < 40) begin
            tick();
            n++;
        end
        check("vld_timeout", res_t'(o_vld), res_t'(1));
    endtask

    vec_t tbl [8];
    op_t  max_v;
    op_t  ra;
    op_t  rb;
    int   n;

    initial begin
        i_rst = 1'b1;
        i_vld = 1'b0;
        i_rdy = 1'b1;
        i_a   = '0;
        i_b   = '0;
`ifdef MMM_KARA3_SQR_EN
        i_sqr = 1'b0;
`endif
        max_v = '1;
        tbl[0].a = max_v;            tbl[0].b = max_v;
        tbl[0].exp = res_t'(0) - (res_t'(1) << 257) + res_t'(1);
        tbl[1].a = '0;               tbl[1].b = max_v;            tbl[1].exp = '0;
        tbl[2].a = op_t'(1) << 255;  tbl[2].b = op_t'(1) << 255;  tbl[2].exp = res_t'(1) << 510;
        tbl[3].a = op_t'(1) << 255;  tbl[3].b = op_t'(2);         tbl[3].exp = res_t'(1) << 256;
        tbl[4].a = op_t'(1);         tbl[4].b = max_v;            tbl[4].exp = res_t'(max_v);
        tbl[5].a = op_t'(1) << 86;   tbl[5].b = op_t'(1) << 86;   tbl[5].exp = res_t'(1) << 172;
        tbl[6].a = (op_t'(1) << 172) - op_t'(1);
        tbl[6].b = (op_t'(1) << 172) - op_t'(1);
        tbl[6].exp = (res_t'(1) << 344) - (res_t'(1) << 173) + res_t'(1);
        tbl[7].a = op_t'(12345);     tbl[7].b = op_t'(67890);     tbl[7].exp = res_t'(838102050);

        repeat (3) tick();
        check("rst_vld", res_t'(o_vld), res_t'(0));
        check("rst_rdy", res_t'(o_rdy), res_t'(1));
        check("rst_busy", res_t'(o_busy), res_t'(0));
        check("rst_res", o_res, res_t'(0));
        i_rst = 1'b0;
        tick();

        // Basic latency and o_vld drop after handshake.
        send(op_t'(3), op_t'(5), res_t'(15), 1'b1);
        wait_vld(n);
        check("latency", res_t'(n), res_t'(9 + MUL_LAT));
        tick();
        check("vld_drop", res_t'(o_vld), res_t'(0));

        // Table, issued back to back from DONE.
        for (int i = 0; i < 8; i++) begin
            send(tbl[i].a, tbl[i].b, tbl[i].exp, 1'b1);
            wait_vld(n);
        end
        tick();

        // Downstream stall holds the result.
        i_rdy = 1'b0;
        send(op_t'(11), op_t'(13), res_t'(143), 1'b1);
        wait_vld(n);
        repeat (5) begin
            tick();
            check("hold_vld", res_t'(o_vld), res_t'(1));
            check("hold_res", o_res, res_t'(143));
            check("hold_rdy", res_t'(o_rdy), res_t'(0));
        end
        i_rdy = 1'b1;
        #1;
        check("rdy_on_release", res_t'(o_rdy), res_t'(1));
        tick();
        check("vld_after_release", res_t'(o_vld), res_t'(0));

        // Same-cycle accept in DONE.
        i_rdy = 1'b0;
        send(op_t'(20), op_t'(30), res_t'(600), 1'b1);
        wait_vld(n);
        i_rdy = 1'b1;
        i_vld = 1'b1;
        i_a   = op_t'(7);
        i_b   = op_t'(9);
        sb.push_back(res_t'(63));
        #1;
        check("b2b_rdy", res_t'(o_rdy), res_t'(1));
        tick();
        i_vld = 1'b0;
        check("b2b_vld_low", res_t'(o_vld), res_t'(0));
        check("b2b_busy", res_t'(o_busy), res_t'(1));
        check("b2b_no_idle", res_t'(o_rdy), res_t'(0));
        wait_vld(n);
        check("b2b_latency", res_t'(n), res_t'(9 + MUL_LAT));
        tick();

        // Reset during DRAIN discards the operation.
        send(op_t'(100), op_t'(100), res_t'(0), 1'b0);
        repeat (7) tick();
        check("drain_busy", res_t'(o_busy), res_t'(1));
        #2;
        i_rst = 1'b1;
        #1;
        check("mid_rst_vld", res_t'(o_vld), res_t'(0));
        check("mid_rst_res", o_res, res_t'(0));
        check("mid_rst_rdy", res_t'(o_rdy), res_t'(1));
        check("mid_rst_busy", res_t'(o_busy), res_t'(0));
        tick();
        i_rst = 1'b0;
        tick();
        send(op_t'(2), op_t'(2), res_t'(4), 1'b1);
        wait_vld(n);
        tick();

        // Random operands with occasional downstream stalls.
        for (int k = 0; k < 300; k++) begin
            ra = rand_op();
            rb = rand_op();
            if (k == 0) ra = '0;
            if (k == 1) rb = '0;
            if (k == 2) ra = op_t'(1) << 255;
            if (k == 3) rb = op_t'(1) << 255;
            send(ra, rb, res_t'(ra) * res_t'(rb), 1'b1);
            wait_vld(n);
            if ($urandom_range(0, 3) == 0) begin
                i_rdy = 1'b0;
                repeat ($urandom_range(1, 4)) tick();
                i_rdy = 1'b1;
            end
        end
        tick();

`ifdef MMM_KARA3_SQR_EN
        i_sqr = 1'b1;
        send((op_t'(1) << 128) + op_t'(1), '0,
             (res_t'(1) << 256) + (res_t'(1) << 129) + res_t'(1), 1'b1);
        i_sqr = 1'b0;
        wait_vld(n);
        tick();
`endif

        repeat (3) tick();
        check("sb_empty", res_t'(sb.size()), res_t'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
